e203_ifu_flushrsp: RTL and testbench

- IFU-side responder for the EXU pipeline-flush handshake (flush_req/ack with add_op1/add_op2).
- Accepts a flush, computes the target PC and drains fetches still in flight, discarding their responses.
- Then issues exactly one redirect to the IFU fetch-PC mux.
- Sits between the EXU commit stage and the IFU fetch/ITCM-BIU request path.

---
 rtl/e203_ifu_flushrsp_pkg.sv | 17 +
 rtl/e203_ifu_flushrsp_if.sv | 40 ++++
 rtl/e203_ifu_outs_cnt.sv | 34 +++
 rtl/e203_ifu_flushrsp.sv | 91 +++++++++
 tb/tb_e203_ifu_flushrsp.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/e203_ifu_flushrsp_pkg.sv
// rtl/e203_ifu_flushrsp_pkg.sv - shared PC width, FSM encoding and target helper for the IFU flush responder
package e203_ifu_flushrsp_pkg;

    localparam int E203_PC_SIZE = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_REDIR = 2'd2
    } flush_state_t;

    // Fetch addresses are halfword aligned, so bit0 of any redirect target is dropped.
    function automatic logic [E203_PC_SIZE-1:0] pc_align(input logic [E203_PC_SIZE-1:0] pc);
        return {pc[E203_PC_SIZE-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/e203_ifu_flushrsp_if.sv
// rtl/e203_ifu_flushrsp_if.sv - EXU flush handshake and IFU fetch/redirect signals (E203_FLUSH_PC_PRECOMP_EN adds pipe_flush_pc)
interface e203_ifu_flushrsp_if;
    import e203_ifu_flushrsp_pkg::*;

    logic                    pipe_flush_req;
    logic                    pipe_flush_ack;
    logic [E203_PC_SIZE-1:0] pipe_flush_add_op1;
    logic [E203_PC_SIZE-1:0] pipe_flush_add_op2;
`ifdef E203_FLUSH_PC_PRECOMP_EN
    logic [E203_PC_SIZE-1:0] pipe_flush_pc;
`endif
    logic                    ifu_req_hsked;
    logic                    ifu_rsp_hsked;
    logic                    ifu_rsp_drop;
    logic                    ifu_redir_valid;
    logic                    ifu_redir_ready;
    logic [E203_PC_SIZE-1:0] ifu_redir_pc;
    logic                    ifu_flush_busy;

    // EXU / fetch-unit side
    modport master (
`ifdef E203_FLUSH_PC_PRECOMP_EN
        output pipe_flush_pc,
`endif
        output pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
        output ifu_req_hsked, ifu_rsp_hsked, ifu_redir_ready,
        input  pipe_flush_ack, ifu_rsp_drop, ifu_redir_valid, ifu_redir_pc, ifu_flush_busy
    );

    // Flush responder side
    modport slave (
`ifdef E203_FLUSH_PC_PRECOMP_EN
        input  pipe_flush_pc,
`endif
        input  pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
        input  ifu_req_hsked, ifu_rsp_hsked, ifu_redir_ready,
        output pipe_flush_ack, ifu_rsp_drop, ifu_redir_valid, ifu_redir_pc, ifu_flush_busy
    );

endinterface

// File: rtl/e203_ifu_outs_cnt.sv
// rtl/e203_ifu_outs_cnt.sv - saturating up/down count of fetch requests still awaiting a response
module e203_ifu_outs_cnt #(
    parameter int OUTS_DEPTH = 2,
    parameter int CW         = $clog2(OUTS_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_cnt
);

    logic [CW-1:0] r_cnt;

    // Count requests up and responses down; simultaneous events cancel, limits hold the value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && (r_cnt != CW'(OUTS_DEPTH))) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_cnt = r_cnt;

    // A request beyond the tracking depth or a response with nothing outstanding is a protocol bug upstream.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_inc && !i_dec && (r_cnt == CW'(OUTS_DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_dec && !i_inc && (r_cnt == '0)));

endmodule

// File: rtl/e203_ifu_flushrsp.sv
// rtl/e203_ifu_flushrsp.sv - accepts EXU flushes, drains stale fetches, issues one redirect (E203_FLUSH_PC_PRECOMP_EN selects precomputed target)
module e203_ifu_flushrsp
    import e203_ifu_flushrsp_pkg::*;
#(
    parameter int OUTS_DEPTH = 2
) (
    input logic                clk,
    input logic                rst_n,
    e203_ifu_flushrsp_if.slave bus
);

    localparam int CW = $clog2(OUTS_DEPTH + 1);

    flush_state_t            r_state;
    logic [E203_PC_SIZE-1:0] r_tgt_pc;
    logic [CW-1:0]           w_cnt;
    logic [CW:0]             w_eff;
    logic                    w_eff_zero;
    logic                    w_ack;
    logic [E203_PC_SIZE-1:0] w_tgt_raw;
    logic [E203_PC_SIZE-1:0] w_tgt_new;

    e203_ifu_outs_cnt #(
        .OUTS_DEPTH (OUTS_DEPTH),
        .CW         (CW)
    ) u_outs_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (bus.ifu_req_hsked),
        .i_dec (bus.ifu_rsp_hsked),
        .o_cnt (w_cnt)
    );

`ifdef E203_FLUSH_PC_PRECOMP_EN
    assign w_tgt_raw = bus.pipe_flush_pc;
`else
    // Carry out of the PC adder is dropped: targets wrap modulo the PC space.
    assign w_tgt_raw = bus.pipe_flush_add_op1 + bus.pipe_flush_add_op2;
`endif
    assign w_tgt_new = pc_align(w_tgt_raw);

    // Fetches that will still be in flight after this cycle's request/response events.
    assign w_eff      = {1'b0, w_cnt} + {{CW{1'b0}}, bus.ifu_req_hsked} - {{CW{1'b0}}, bus.ifu_rsp_hsked};
    assign w_eff_zero = (w_eff == '0);

    assign w_ack = bus.pipe_flush_req && ((r_state == ST_IDLE) || (r_state == ST_REDIR));

    assign bus.pipe_flush_ack  = w_ack;
    assign bus.ifu_rsp_drop    = bus.ifu_rsp_hsked &&
                                 ((r_state == ST_DRAIN) || ((r_state == ST_IDLE) && w_ack));
    assign bus.ifu_redir_valid = (r_state == ST_REDIR);
    // A flush accepted while a redirect is offered replaces that redirect's target immediately.
    assign bus.ifu_redir_pc    = ((r_state == ST_REDIR) && w_ack) ? w_tgt_new : r_tgt_pc;
    assign bus.ifu_flush_busy  = (r_state != ST_IDLE);

    // Flush FSM: latch target on ack, wait out stale fetches, then hold the redirect until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_tgt_pc <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ack) begin
                        r_tgt_pc <= w_tgt_new;
                        r_state  <= w_eff_zero ? ST_REDIR : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_eff_zero) begin
                        r_state <= ST_REDIR;
                    end
                end
                ST_REDIR: begin
                    if (w_ack) begin
                        r_tgt_pc <= w_tgt_new;
                        if (bus.ifu_redir_ready) begin
                            r_state <= ST_IDLE;
                        end else if (!w_eff_zero) begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (bus.ifu_redir_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e203_ifu_flushrsp.sv
// tb/tb_e203_ifu_flushrsp.sv - vector table, corner sequences and randomized model check for e203_ifu_flushrsp
module tb_e203_ifu_flushrsp;
    import e203_ifu_flushrsp_pkg::*;

    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    e203_ifu_flushrsp_if bus ();

    e203_ifu_flushrsp #(.OUTS_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        reqh;
        logic        rsph;
        logic        ready;
        logic        e_ack;
        logic        e_drop;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] op1, input logic [31:0] op2,
                         input logic reqh, input logic rsph, input logic ready);
        bus.pipe_flush_req     = req;
        bus.pipe_flush_add_op1 = op1;
        bus.pipe_flush_add_op2 = op2;
`ifdef E203_FLUSH_PC_PRECOMP_EN
        bus.pipe_flush_pc      = op1 + op2;
`endif
        bus.ifu_req_hsked      = reqh;
        bus.ifu_rsp_hsked      = rsph;
        bus.ifu_redir_ready    = ready;
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        drive(v.req, v.op1, v.op2, v.reqh, v.rsph, v.ready);
        #1;
        chk({tag, ".ack"},   32'(bus.pipe_flush_ack),  32'(v.e_ack));
        chk({tag, ".drop"},  32'(bus.ifu_rsp_drop),    32'(v.e_drop));
        chk({tag, ".valid"}, 32'(bus.ifu_redir_valid), 32'(v.e_valid));
        chk({tag, ".busy"},  32'(bus.ifu_flush_busy),  32'(v.e_busy));
        if (v.e_valid) chk({tag, ".pc"}, bus.ifu_redir_pc, v.e_pc);
    endtask

    function automatic vec_t mk(input logic req, input logic [31:0] op1, input logic [31:0] op2,
                                input logic reqh, input logic rsph, input logic ready,
                                input logic ack, input logic drop, input logic valid,
                                input logic [31:0] pc, input logic busy);
        vec_t v;
        v.req = req; v.op1 = op1; v.op2 = op2; v.reqh = reqh; v.rsph = rsph; v.ready = ready;
        v.e_ack = ack; v.e_drop = drop; v.e_valid = valid; v.e_pc = pc; v.e_busy = busy;
        return v;
    endfunction

    // Reference model state: counts of in-flight and stale fetches plus the pending redirect.
    int          m_outs;
    int          m_stale;
    bit          m_pend;
    logic [31:0] m_tgt;

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst.ack",   32'(bus.pipe_flush_ack),  0);
        chk("rst.drop",  32'(bus.ifu_rsp_drop),    0);
        chk("rst.valid", 32'(bus.ifu_redir_valid), 0);
        chk("rst.busy",  32'(bus.ifu_flush_busy),  0);
        chk("rst.pc",    bus.ifu_redir_pc,         0);
        rst_n = 1'b1;

        //        req op1           op2           rqh rsh rdy  ack drp val pc            busy
        tbl.push_back(mk(1, 32'h8000_0100, 32'h0000_0010, 0, 0, 0,  1, 0, 0, 32'h0,         0));
        tbl.push_back(mk(0, 32'h0,         32'h0,         0, 0, 0,  0, 0, 1, 32'h8000_0110, 1));
        tbl.push_back(mk(0, 32'h0,         32'h0,         0, 0, 1,  0, 0, 1, 32'h8000_0110, 1));
        tbl.push_back(mk(0, 32'h0,         32'h0,         1, 0, 0,  0, 0, 0, 32'h0,         0));
        tbl.push_back(mk(0, 32'h0,         32'h0,         1, 0, 0,  0, 0, 0, 32'h0,         0));
        tbl.push_back(mk(1, 32'h0000_0100, 32'h0,         0, 0, 0,  1, 0, 0, 32'h0,         0));
        tbl.push_back(mk(0, 32'h0,         32'h0,         0, 1, 0,  0, 1, 0, 32'h0,         1));
        tbl.push_back(mk(0, 32'h0,         32'h0,         0, 0, 0,  0, 0, 0, 32'h0,         1));
        tbl.push_back(mk(0, 32'h0,         32'h0,         0, 1, 0,  0, 1, 0, 32'h0,         1));
        tbl.push_back(mk(0, 32'h0,         32'h0,         0, 0, 0,  0, 0, 1, 32'h0000_0100, 1));
        tbl.push_back(mk(1, 32'h0000_0200, 32'h0000_0004, 0, 0, 0,  1, 0, 1, 32'h0000_0204, 1));
        tbl.push_back(mk(0, 32'h0,         32'h0,         0, 0, 1,  0, 0, 1, 32'h0000_0204, 1));
        tbl.push_back(mk(0, 32'h0,         32'h0,         0, 0, 0,  0, 0, 0, 32'h0,         0));
        tbl.push_back(mk(1, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0, 0,  1, 0, 0, 32'h0,         0));
        tbl.push_back(mk(0, 32'h0,         32'h0,         0, 0, 1,  0, 0, 1, 32'h0000_0000, 1));
        tbl.push_back(mk(0, 32'h0,         32'h0,         1, 0, 0,  0, 0, 0, 32'h0,         0));
        tbl.push_back(mk(1, 32'h0000_0040, 32'h0000_0002, 0, 1, 0,  1, 1, 0, 32'h0,         0));
        tbl.push_back(mk(0, 32'h0,         32'h0,         0, 0, 1,  0, 0, 1, 32'h0000_0042, 1));
        tbl.push_back(mk(0, 32'h0,         32'h0,         0, 0, 0,  0, 0, 0, 32'h0,         0));
        foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i]);

        // Flush held off while draining, then accepted together with redirect consumption.
        apply("hd0", mk(0, 32'h0,   32'h0, 1, 0, 0,  0, 0, 0, 32'h0,   0));
        apply("hd1", mk(0, 32'h0,   32'h0, 1, 0, 0,  0, 0, 0, 32'h0,   0));
        apply("hd2", mk(1, 32'h300, 32'h0, 0, 0, 0,  1, 0, 0, 32'h0,   0));
        apply("hd3", mk(1, 32'h500, 32'h8, 0, 1, 0,  0, 1, 0, 32'h0,   1));
        apply("hd4", mk(1, 32'h500, 32'h8, 1, 0, 0,  0, 0, 0, 32'h0,   1));
        apply("hd5", mk(1, 32'h500, 32'h8, 0, 1, 0,  0, 1, 0, 32'h0,   1));
        apply("hd6", mk(1, 32'h500, 32'h8, 0, 1, 0,  0, 1, 0, 32'h0,   1));
        apply("hd7", mk(1, 32'h500, 32'h8, 0, 0, 1,  1, 0, 1, 32'h508, 1));
        apply("hd8", mk(0, 32'h0,   32'h0, 0, 0, 0,  0, 0, 0, 32'h0,   0));

        // Asynchronous reset in the middle of a drain.
        apply("rd0", mk(0, 32'h0,   32'h0, 1, 0, 0,  0, 0, 0, 32'h0,   0));
        apply("rd1", mk(1, 32'h700, 32'h0, 0, 0, 0,  1, 0, 0, 32'h0,   0));
        apply("rd2", mk(0, 32'h0,   32'h0, 0, 0, 0,  0, 0, 0, 32'h0,   1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.busy",  32'(bus.ifu_flush_busy),     0);
        chk("arst.valid", 32'(bus.ifu_redir_valid),    0);
        chk("arst.cnt",   32'(dut.u_outs_cnt.o_cnt),   0);
        chk("arst.pc",    bus.ifu_redir_pc,            0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the counting model.
        m_outs = 0; m_stale = 0; m_pend = 0; m_tgt = '0;
        begin
            logic        h_req;
            logic [31:0] h_op1, h_op2, t, e_pc;
            logic        rsph, reqh, ready, e_ack, e_drop, e_valid;
            int          nxt;
            h_req = 0; h_op1 = '0; h_op2 = '0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (!h_req && ($urandom_range(0, 3) == 0)) begin
                    h_req = 1;
                    h_op1 = $urandom();
                    h_op2 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
                end
                rsph  = (m_outs > 0) && ($urandom_range(0, 2) == 0);
                reqh  = ((m_outs < DEPTH) || rsph) && ($urandom_range(0, 2) == 0);
                ready = $urandom_range(0, 1) == 1;
                drive(h_req, h_op1, h_op2, reqh, rsph, ready);
                #1;
                t       = (h_op1 + h_op2) & 32'hFFFF_FFFE;
                e_valid = m_pend && (m_stale == 0);
                e_ack   = h_req && !(m_pend && (m_stale > 0));
                e_drop  = rsph && ((m_pend && (m_stale > 0)) || (!m_pend && e_ack));
                e_pc    = e_ack ? t : m_tgt;
                chk("rnd.ack",   32'(bus.pipe_flush_ack),  32'(e_ack));
                chk("rnd.drop",  32'(bus.ifu_rsp_drop),    32'(e_drop));
                chk("rnd.valid", 32'(bus.ifu_redir_valid), 32'(e_valid));
                chk("rnd.busy",  32'(bus.ifu_flush_busy),  32'(m_pend));
                if (e_valid) chk("rnd.pc", bus.ifu_redir_pc, e_pc);
                nxt = m_outs + int'(reqh) - int'(rsph);
                if (e_ack) begin
                    m_tgt = t;
                    h_req = 0;
                    if (e_valid && ready) begin
                        m_pend = 0; m_stale = 0;
                    end else begin
                        m_pend = 1; m_stale = nxt;
                    end
                end else begin
                    if (m_pend && (m_stale > 0)) m_stale = nxt;
                    else if (e_valid && ready) m_pend = 0;
                end
                m_outs = nxt;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
